// File: rtl/trdb_packet_packer.sv
`default_nettype none
// ============================================================================
// Module      : trdb_packet_packer
// Description : Packs variable-length trace packets LSB-first, back to back,
//               into fixed BUSW-bit words behind a valid/ready handshake.
//               A flush request zero-pads and drains any partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module trdb_packet_packer #(
    parameter int PACKET_LEN = 64,
    parameter int BUSW       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [PACKET_LEN-1:0] packet_bits_i,
    input  logic [6:0]            packet_len_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [BUSW-1:0]       word_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  len_err_o
);

    // Staging buffer must hold a partial word plus one full packet.
    localparam int BUF_LEN = PACKET_LEN + BUSW;

    localparam logic [7:0] c_busw = 8'(BUSW);
    localparam logic [7:0] c_plen = 8'(PACKET_LEN);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BUF_LEN-1:0] r_buf;
    logic [BUF_LEN-1:0] w_buf_next;
    logic [7:0]         r_fill;
    logic [7:0]         w_fill_next;
    logic               r_flush_done;
    logic               w_flush_done_next;
    logic               r_len_err;

    logic [7:0]         w_len_ext;
    logic               w_len_over;
    logic [7:0]         w_len;
    logic [BUF_LEN-1:0] w_mask;
    logic [BUF_LEN-1:0] w_payload;
    logic [BUF_LEN-1:0] w_insert;
    logic [7:0]         w_fill_pop;
    logic               w_accept;
    logic               w_pop;

    // Clamp the packet length and build the masked payload at buffer width so
    // the shift by fill never truncates valid bits.
    always_comb begin
        w_len_ext  = {1'b0, packet_len_i};
        w_len_over = (w_len_ext > c_plen);
        w_len      = w_len_over ? c_plen : w_len_ext;
        w_mask     = ~({BUF_LEN{1'b1}} << w_len);
        w_payload  = {{BUSW{1'b0}}, packet_bits_i} & w_mask;
        w_insert   = w_payload << r_fill;
        w_fill_pop = (r_fill > c_busw) ? (r_fill - c_busw) : 8'd0;
    end

    // Handshake outputs depend on registered state only.
    assign ready_o      = (r_state == ST_IDLE) && (r_fill < c_busw);
    assign word_valid_o = (r_fill >= c_busw) || ((r_state == ST_DRAIN) && (r_fill != 8'd0));
    assign word_o       = r_buf[BUSW-1:0];
    assign flush_done_o = r_flush_done;
    assign len_err_o    = r_len_err;

    assign w_accept = valid_i && ready_o;
    assign w_pop    = word_valid_o && word_ready_i;

    // Next buffer/fill and FSM transition; accept and pop are mutually exclusive.
    always_comb begin
        w_buf_next        = r_buf;
        w_fill_next       = r_fill;
        w_state_next      = r_state;
        w_flush_done_next = 1'b0;

        if (w_accept) begin
            w_buf_next  = r_buf | w_insert;
            w_fill_next = r_fill + w_len;
        end else if (w_pop) begin
            w_buf_next  = r_buf >> BUSW;
            w_fill_next = w_fill_pop;
        end

        case (r_state)
            ST_IDLE: begin
                if (flush_i) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that empties the buffer.
                if (w_fill_next == 8'd0) begin
                    w_state_next      = ST_IDLE;
                    w_flush_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards buffered bits without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_fill       <= 8'd0;
            r_flush_done <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_buf        <= w_buf_next;
            r_fill       <= w_fill_next;
            r_flush_done <= w_flush_done_next;
            if (w_accept && w_len_over) begin
                r_len_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trdb_packet_packer
// Description : Self-checking bench for trdb_packet_packer with a bitstream
//               scoreboard plus directed boundary checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_packet_packer;

    localparam int PL = 64;
    localparam int BW = 32;

    logic          clk_i         = 1'b0;
    logic          rst_i         = 1'b1;
    logic          valid_i       = 1'b0;
    logic          ready_o;
    logic [PL-1:0] packet_bits_i = '0;
    logic [6:0]    packet_len_i  = '0;
    logic          flush_i       = 1'b0;
    logic          flush_done_o;
    logic [BW-1:0] word_o;
    logic          word_valid_o;
    logic          word_ready_i  = 1'b0;
    logic          len_err_o;

    trdb_packet_packer #(.PACKET_LEN(PL), .BUSW(BW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .packet_bits_i (packet_bits_i),
        .packet_len_i  (packet_len_i),
        .flush_i       (flush_i),
        .flush_done_o  (flush_done_o),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .len_err_o     (len_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: accepted payload bits go into a bit queue; every popped word
    // must equal the next BW bits of that stream, zero-padded when short.
    bit            exp_q[$];
    int            n_words   = 0;
    logic [BW-1:0] last_word = '0;
    int            m_len;
    logic [BW-1:0] m_exp;

    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (valid_i && ready_o) begin
                m_len = (packet_len_i > 7'd64) ? PL : int'(packet_len_i);
                for (int i = 0; i < m_len; i++) exp_q.push_back(packet_bits_i[i]);
            end
            if (word_valid_o && word_ready_i) begin
                check_eq("sb_word_has_data", (exp_q.size() != 0), 1);
                m_exp = '0;
                for (int i = 0; i < BW; i++)
                    if (exp_q.size() > 0) m_exp[i] = exp_q.pop_front();
                check_eq("sb_word", word_o, m_exp);
                n_words++;
                last_word = word_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [63:0] bits, input int len);
        int w;
        w = 0;
        while (!ready_o && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) check_eq("send_ready_timeout", w, 0);
        valid_i       = 1'b1;
        packet_bits_i = bits;
        packet_len_i  = 7'(len);
        tick();
        valid_i       = 1'b0;
    endtask

    task automatic flush_and_wait();
        int w;
        bit got;
        w   = 0;
        got = 0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        while (w < 300) begin
            @(negedge clk_i);
            if (flush_done_o) begin
                got = 1;
                break;
            end
            w++;
        end
        check_eq("flush_done_seen", got, 1);
        @(negedge clk_i);
        check_eq("flush_done_one_cycle", flush_done_o, 0);
        tick();
    endtask

    int  w0;
    bit  rnd_done = 0;

    initial begin
        // Reset values
        repeat (2) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_word_valid", word_valid_o, 0);
        check_eq("rst_flush_done", flush_done_o, 0);
        tick();

        // 1: reset in the middle of activity
        word_ready_i = 1'b0;
        send(64'hFFFF, 16);
        send({64{1'b1}}, 70);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("t1_word_valid", word_valid_o, 0);
        check_eq("t1_flush_done", flush_done_o, 0);
        check_eq("t1_len_err", len_err_o, 0);
        check_eq("t1_ready", ready_o, 1);
        check_eq("t1_fill", dut.r_fill, 0);
        check_eq("t1_word", word_o, 0);
        tick();

        // 2: two 20-bit packets form one word
        word_ready_i = 1'b1;
        w0 = n_words;
        send(64'hABCDE, 20);
        send(64'h12345, 20);
        repeat (3) tick();
        check_eq("t2_nwords", n_words - w0, 1);
        check_eq("t2_word", last_word, 32'h345ABCDE);
        check_eq("t2_fill", dut.r_fill, 8);
        check_eq("t2_ready", ready_o, 1);

        // 3: flush drains the 8-bit residue, then flush on empty buffer
        w0 = n_words;
        flush_and_wait();
        check_eq("t3_nwords", n_words - w0, 1);
        check_eq("t3_word", last_word, 32'h12);
        check_eq("t3_fill", dut.r_fill, 0);
        w0 = n_words;
        flush_and_wait();
        check_eq("t3_empty_nwords", n_words - w0, 0);

        // 4: fill 31 plus a full 64-bit packet under backpressure
        word_ready_i = 1'b0;
        send(64'h7FFF_FFFF, 31);
        check_eq("t4_fill31", dut.r_fill, 31);
        send({64{1'b1}}, 64);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check_eq("t4_stall_valid", word_valid_o, 1);
            check_eq("t4_stall_word", word_o, 32'hFFFFFFFF);
            check_eq("t4_stall_ready", ready_o, 0);
        end
        tick();
        word_ready_i = 1'b1;
        w0 = n_words;
        @(negedge clk_i);
        check_eq("t4_w1_valid", word_valid_o, 1);
        check_eq("t4_w1", word_o, 32'hFFFFFFFF);
        @(negedge clk_i);
        check_eq("t4_w2_valid", word_valid_o, 1);
        check_eq("t4_w2", word_o, 32'hFFFFFFFF);
        @(negedge clk_i);
        check_eq("t4_after_valid", word_valid_o, 0);
        check_eq("t4_after_fill", dut.r_fill, 31);
        check_eq("t4_after_ready", ready_o, 1);
        check_eq("t4_nwords", n_words - w0, 2);
        tick();

        // 5: oversize length clamps and sets the sticky error; zero length is a no-op
        check_eq("t5_len_err_before", len_err_o, 0);
        send({64{1'b1}}, 70);
        repeat (4) tick();
        check_eq("t5_len_err", len_err_o, 1);
        check_eq("t5_fill", dut.r_fill, 31);
        send(64'hDEAD, 0);
        tick();
        check_eq("t5_len0_fill", dut.r_fill, 31);
        check_eq("t5_len_err_sticky", len_err_o, 1);
        flush_and_wait();
        check_eq("t5_drain_word", last_word, 32'h7FFFFFFF);
        check_eq("t5_len_err_after_flush", len_err_o, 1);

        // 6: random stream with random sink backpressure, then final flush
        w0 = n_words;
        fork
            begin
                for (int k = 0; k < 300; k++)
                    send({$urandom, $urandom}, int'($urandom_range(0, 64)));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    word_ready_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        word_ready_i = 1'b1;
        flush_and_wait();
        check_eq("t6_sb_empty", exp_q.size(), 0);
        check_eq("t6_words_seen", (n_words - w0 > 100), 1);
        check_eq("t6_fill", dut.r_fill, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
